booth_mult_seq: RTL



---
 rtl/booth_mult_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// Multi-cycle radix-2 Booth multiplier with start/busy/ready handshake.
// Signed or unsigned WIDTH-bit operands give a full 2*WIDTH-bit product; latency is fixed.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     result,
  output logic                 exception,
  output logic                 busy,
  output logic                 ready
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH+1:0]   acc;
  logic [WIDTH:0]     q;
  logic [WIDTH:0]     mcand;
  logic               q_1;
  logic               sgn;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH:0]     a_ext, b_ext;
  logic [WIDTH+1:0]   mc2, sum;
  logic [WIDTH+1:0]   acc_sh;
  logic [WIDTH:0]     q_sh;
  logic [2*WIDTH-1:0] prod_n;
  logic [WIDTH:0]     top_n;
  logic               exc_n;
  logic               last;

  always_comb begin
    a_ext = is_signed ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
    b_ext = is_signed ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};
  end

  // One Booth step; the final step feeds the product register directly.
  always_comb begin
    mc2 = {mcand[WIDTH], mcand};
    sum = acc;
    case ({q[0], q_1})
      2'b10:   sum = acc - mc2;
      2'b01:   sum = acc + mc2;
      default: sum = acc;
    endcase
    acc_sh = {sum[WIDTH+1], sum[WIDTH+1:1]};
    q_sh   = {sum[0], q[WIDTH:1]};
    prod_n = {acc_sh[WIDTH-2:0], q_sh};
    top_n  = prod_n[2*WIDTH-1:WIDTH-1];
    if (sgn) exc_n = !((&top_n) || (top_n == '0));
    else     exc_n = (prod_n[2*WIDTH-1:WIDTH] != '0);
    last = (cnt == CNT_W'(WIDTH));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      mcand     <= '0;
      sgn       <= 1'b0;
      cnt       <= '0;
      product   <= '0;
      exception <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state <= state_n;
      ready <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          mcand <= a_ext;
          q     <= b_ext;
          acc   <= '0;
          q_1   <= 1'b0;
          sgn   <= is_signed;
          cnt   <= '0;
        end
        RUN: begin
          acc <= acc_sh;
          q   <= q_sh;
          q_1 <= q[0];
          cnt <= cnt + 1'b1;
          if (last) begin
            product   <= prod_n;
            exception <= exc_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = product[WIDTH-1:0];
  assign busy   = (state != IDLE);

endmodule
